// File: rtl/muladd.sv
// -----------------------------------------------------------------------------
// muladd: sequential multiply-add, res = a*b + c, using a shift-and-add datapath.
//
// It rebuilds a numerator from the quotient (a), divisor (b) and remainder (c)
// of a divrem result. It uses the same go/ready/error handshake as divrem.
// Latency is fixed at WIDTH cycles from accept to ready.
//
// Ports:
//   clk_i    system clock, all state changes on the rising edge
//   rst_i    synchronous active-high reset, has priority over go_i
//   go_i     start request, honoured only while ready_o = 1
//   a_i      multiplicand (quotient)
//   b_i      multiplier (divisor)
//   c_i      addend (remainder)
//   ready_o  idle / result valid
//   error_o  result overflowed WIDTH bits, or c >= b (this includes b = 0)
//   res_o    low WIDTH bits of a*b + c
// -----------------------------------------------------------------------------
module muladd #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             go_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] c_i,
    output logic             ready_o,
    output logic             error_o,
    output logic [WIDTH-1:0] res_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    // Control state (reset)
    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               error_q, error_d;

    // Datapath state (loaded at accept)
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               invalid_q, invalid_d;   // captured c >= b

    // Accumulator value after this cycle's conditional add. The 2*WIDTH
    // accumulator cannot wrap, because (2^W-1)^2 + 2^W-1 < 2^(2W).
    logic [2*WIDTH-1:0] acc_step;

    always_comb begin
        // NOTE: every signal this block drives gets a default first, so
        // branches that do not mention it hold state and infer no latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        error_d   = error_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        invalid_d = invalid_q;
        acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

        case (state_q)
            IDLE: begin
                if (go_i) begin
                    mcand_d   = {{WIDTH{1'b0}}, a_i};
                    mplier_d  = b_i;
                    acc_d     = {{WIDTH{1'b0}}, c_i};
                    invalid_d = (c_i >= b_i);
                    cnt_d     = '0;
                    res_d     = '0;
                    error_d   = 1'b0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // No early exit: the last step always runs at count WIDTH-1.
                if (cnt_q == LAST_STEP) begin
                    state_d = IDLE;
                    res_d   = acc_step[WIDTH-1:0];
                    error_d = (|acc_step[2*WIDTH-1:WIDTH]) | invalid_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the values from before the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            error_q <= error_d;
        end
    end

    // NOTE: the datapath registers have no reset. They are always loaded at
    // accept before anything reads them, so a reset would add only fanout.
    always_ff @(posedge clk_i) begin
        mcand_q   <= mcand_d;
        mplier_q  <= mplier_d;
        acc_q     <= acc_d;
        invalid_q <= invalid_d;
    end

    assign ready_o = (state_q == IDLE);
    assign error_o = error_q;
    assign res_o   = res_q;

endmodule

// File: tb/tb_muladd.sv
// -----------------------------------------------------------------------------
// tb_muladd: directed scoreboard bench for muladd (WIDTH = 16).
// The stimulus pushes the expected {res, error, busy length} for each accepted
// operation. A monitor pops and compares each entry on every rising edge of
// ready.
// -----------------------------------------------------------------------------
module tb_muladd;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         go  = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [W-1:0] c   = '0;
    logic         ready;
    logic         error;
    logic [W-1:0] res;

    int tests  = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0] res;
        logic         err;
        int           lat;   // expected busy cycles, -1 when aborted by reset
    } exp_t;

    exp_t exp_q[$];

    int cycle      = 0;
    int last_rise  = -1;
    int rise_gap   = 0;

    muladd #(.WIDTH(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .go_i    (go),
        .a_i     (a),
        .b_i     (b),
        .c_i     (c),
        .ready_o (ready),
        .error_o (error),
        .res_o   (res)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    // Monitor: compare on each 0->1 transition of ready, sampled at negedge.
    logic prev_ready = 1'b1;
    int   busy_cnt   = 0;
    always @(negedge clk) begin
        exp_t e;
        if (ready === 1'b0) busy_cnt++;
        if (ready === 1'b1 && prev_ready === 1'b0) begin
            if (last_rise >= 0) rise_gap = cycle - last_rise;
            last_rise = cycle;
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("res", 32'(res), 32'(e.res));
                check("error", 32'(error), 32'(e.err));
                if (e.lat >= 0) check("latency", 32'(busy_cnt), 32'(e.lat));
            end
            busy_cnt = 0;
        end
        prev_ready = ready;
    end

    // Wait at negedges until ready is high, bounded by a cycle budget.
    task automatic wait_ready(input int budget);
        int n = 0;
        @(negedge clk);
        while (ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one operation with a one-cycle go pulse. The task returns at the
    // first busy negedge.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ic, input logic [W-1:0] er,
                          input logic ee, input int lat);
        exp_t e;
        wait_ready(40);
        a  = ia;
        b  = ib;
        c  = ic;
        go = 1'b1;
        e.res = er;
        e.err = ee;
        e.lat = lat;
        exp_q.push_back(e);
        @(negedge clk);
        go = 1'b0;
    endtask

    initial begin
        logic [W-1:0] q;
        logic [W-1:0] r;
        exp_t         e;
        int           n;

        // Reset held 3 cycles
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_error", 32'(error), 32'd0);
        check("rst_res", 32'(res), 32'd0);

        // go while rst is high has no effect
        rst = 1'b1;
        a = 16'd9; b = 16'd9; c = 16'd1; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rstgo_ready", 32'(ready), 32'd1);
        check("rstgo_res", 32'(res), 32'd0);

        // Basic operation and boundaries
        run_op(16'd7,   16'd3,   16'd2, 16'd23,    1'b0, 16);
        run_op(16'd255, 16'd257, 16'd0, 16'd65535, 1'b0, 16);
        run_op(16'd256, 16'd256, 16'd0, 16'd0,     1'b1, 16);
        run_op(16'd0,   16'd0,   16'd0, 16'd0,     1'b1, 16);
        run_op(16'd4,   16'd5,   16'd5, 16'd25,    1'b1, 16);
        // 0xFFFF*0xFFFF + 0xFFFF = 0xFFFF0000
        run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b1, 16);
        run_op(16'd1000, 16'd60, 16'd59, 16'd60059, 1'b0, 16);

        // Round trip with divrem results. For den = 0, divrem is taken to
        // return quot = all ones and rem = num.
        for (int num = 0; num < 20; num++) begin
            for (int den = 0; den < 20; den++) begin
                if (den != 0) begin
                    q = W'(num / den);
                    r = W'(num % den);
                    run_op(q, W'(den), r, W'(num), 1'b0, 16);
                end else begin
                    run_op(16'hFFFF, 16'd0, W'(num), W'(num), 1'b1, 16);
                end
            end
        end

        // go during BUSY cycle 5 with other operands is ignored
        run_op(16'd7, 16'd3, 16'd2, 16'd23, 1'b0, 16);
        repeat (4) @(negedge clk);
        a = 16'd9; b = 16'd9; c = 16'd9; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        wait_ready(40);
        repeat (3) @(negedge clk);
        check("ignored_go_idle", 32'(ready), 32'd1);
        check("ignored_go_res", 32'(res), 32'd23);

        // go held high: two results 17 cycles apart (10*20+5 = 205)
        wait_ready(40);
        a = 16'd10; b = 16'd20; c = 16'd5; go = 1'b1;
        e.res = 16'd205; e.err = 1'b0; e.lat = 16;
        exp_q.push_back(e);
        exp_q.push_back(e);
        repeat (34) @(negedge clk);
        go = 1'b0;
        wait_ready(40);
        repeat (2) @(negedge clk);
        check("held_go_gap", 32'(rise_gap), 32'd17);
        check("held_go_idle", 32'(ready), 32'd1);

        // Reset at BUSY cycle 8 aborts; result reads 0/0
        run_op(16'd100, 16'd100, 16'd0, 16'd0, 1'b0, -1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_res", 32'(res), 32'd0);
        check("abort_error", 32'(error), 32'd0);
        run_op(16'd2, 16'd3, 16'd1, 16'd7, 1'b0, 16);

        // Drain the scoreboard
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/muladd.md
# muladd

Sequential multiply-add unit computing `res = a*b + c` with a shift-and-add datapath. It is the inverse companion of `divrem`: it reconstructs a numerator from quotient (`a`), divisor (`b`) and remainder (`c`), and uses the same `go`/`ready`/`error` handshake. The prime generator uses it to cross-check divider results and to form candidate products.

## Interface
- `WIDTH`, default 16: operand and result width in bits.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  start request; honoured only on an edge where `ready`=1.
- `a`  in  WIDTH  multiplicand (quotient).
- `b`  in  WIDTH  multiplier (divisor).
- `c`  in  WIDTH  addend (remainder).
- `ready`  out  1  idle / result valid.
- `error`  out  1  result invalid as a `divrem` inverse (see Operation).
- `res`  out  WIDTH  low WIDTH bits of `a*b + c`.

## Operation
- States: IDLE (`ready`=1), BUSY (`ready`=0).
- Reset (`rst`=1 at an edge): state←IDLE, `ready`=1, `error`=0, `res`=0, counter=0. Reset has priority over `go` and aborts any BUSY operation; the partial result is discarded.
- Accept: an edge with `rst`=0, `go`=1, `ready`=1.
  - Loads `mcand`=a (2·WIDTH bits), `mplier`=b, `acc`=c (2·WIDTH bits), `cnt`=0.
  - Clears `res` and `error` to 0; state←BUSY.
- Operands are sampled only at accept. Later changes on `a`/`b`/`c` have no effect.
- BUSY step, once per edge:
  - If `mplier[0]`: `acc`←`acc`+`mcand`.
  - Then `mcand`←`mcand`<<1, `mplier`←`mplier`>>1, `cnt`←`cnt`+1.
  - There is no early termination, so latency is fixed.
- Completion: at the edge performing step WIDTH-1:
  - state←IDLE, `ready`←1.
  - `res`←`acc_final[WIDTH-1:0]`.
  - `error`←`(acc_final[2·WIDTH-1:WIDTH] != 0) | (c_captured >= b_captured)`.
- Error covers two cases:
  - Overflow: the true result is ≥ 2^WIDTH.
  - Invalid remainder: `c` ≥ `b`, which includes `b`=0.
- `res` still carries the low bits when `error`=1.
- The 2·WIDTH accumulator cannot overflow, because (2^W-1)² + 2^W-1 < 2^(2W).
- `go` while BUSY is ignored and not queued.
- `res` and `error` hold their values in IDLE until the next accept or reset.

## Timing
- Accept at edge k: `ready` low after edge k.
- Steps run at edges k+1 … k+WIDTH. `ready`, `res` and `error` are valid after edge k+WIDTH.
- Latency: WIDTH cycles from accept to `ready`=1. For WIDTH=16 this is 16 cycles, 160 ns at a 10 ns clock.
- Back-to-back operation: `go` held high restarts at edge k+WIDTH+1. The prior result is visible for exactly one cycle.
- Reset asserted during BUSY: after that edge `ready`=1, `res`=0, `error`=0. An accept is possible on the next edge.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset:
  - Hold `rst` 3 cycles, then check `ready`=1, `error`=0, `res`=0.
  - Pulse `go` with `rst`=1: still idle, `res`=0.
- Basic:
  - a=7, b=3, c=2, one-cycle `go`: `ready` low exactly 16 cycles, then `res`=23, `error`=0.
- Boundaries:
  - a=255, b=257, c=0: `res`=65535, `error`=0.
  - a=256, b=256, c=0: `res`=0, `error`=1 (overflow).
  - a=0, b=0, c=0: `res`=0, `error`=1 (`b`=0).
  - a=4, b=5, c=5: `res`=25, `error`=1 (`c` ≥ `b`).
- Round trip with `divrem`:
  - For num, den in 0..19, run `divrem`, then feed its quot/den/rem here.
  - den≠0: `res`=num, `error`=0.
  - den=0: `error`=1.
- Handshake:
  - `go` pulsed at BUSY cycle 5 with other operands: ignored, original result returned at cycle 16.
  - `go` held high: consecutive results 16+1 cycles apart.
- Reset mid-operation:
  - Accept a=100, b=100, assert `rst` at BUSY cycle 8: next cycle `ready`=1, `res`=0, `error`=0.
  - Then accept a=2, b=3, c=1: `res`=7, `error`=0.
